// File: rtl/barrel_rotator_left_pipe_if.sv
// Streaming handshake bundle for the pipelined rotate-left shifter.
interface barrel_rotator_left_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data;
  logic [AMT_W-1:0] amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [AMT_W-1:0] out_amt;

  // Rotator side: consumes the input stream, produces the output stream
  modport slave (
    input  in_valid, data, amt, out_ready,
    output in_ready, out_valid, out, out_amt
  );

  // Environment side: produces the input stream, consumes the output stream
  modport master (
    output in_valid, data, amt, out_ready,
    input  in_ready, out_valid, out, out_amt
  );
endinterface

// File: rtl/barrel_rotator_left_pipe.sv
// Pipelined rotate-left barrel shifter, one register stage per amount bit.
// Stage s (0-based) rotates by WIDTH>>(s+1) when amt bit AMT_W-1-s is set.
// The whole pipe advances together whenever the output slot is free or drained.
module barrel_rotator_left_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  barrel_rotator_left_pipe_if.slave   bus
);

  // Fixed-distance rotate left; sh is always in 1..WIDTH/2 here
  function automatic logic [WIDTH-1:0] rotl_by(input logic [WIDTH-1:0] x,
                                               input int unsigned      sh);
    return (x << sh) | (x >> (WIDTH - sh));
  endfunction

  logic w_adv;

  // Global advance: last stage empty or being drained this cycle
  assign w_adv       = ~g_stage[AMT_W-1].r_valid | bus.out_ready;
  assign bus.in_ready = w_adv;

  for (genvar s = 0; s < AMT_W; s++) begin : g_stage
    logic             w_src_valid;
    logic [WIDTH-1:0] w_src_word;
    logic [AMT_W-1:0] w_src_amt;
    logic [WIDTH-1:0] w_rot;
    logic             r_valid;
    logic [WIDTH-1:0] r_word;
    logic [AMT_W-1:0] r_amt;

    if (s == 0) begin : g_first
      assign w_src_valid = bus.in_valid;
      assign w_src_word  = bus.data;
      assign w_src_amt   = bus.amt;
    end else begin : g_next
      assign w_src_valid = g_stage[s-1].r_valid;
      assign w_src_word  = g_stage[s-1].r_word;
      assign w_src_amt   = g_stage[s-1].r_amt;
    end

    // Conditional rotate by this stage's power-of-two distance
    always_comb begin
      w_rot = w_src_word;
      if (w_src_amt[AMT_W-1-s]) begin
        w_rot = rotl_by(w_src_word, WIDTH >> (s + 1));
      end
    end

    // Stage register; holds everything while the pipe is stalled
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_word  <= '0;
        r_amt   <= '0;
      end else if (w_adv) begin
        r_valid <= w_src_valid;
        r_word  <= w_rot;
        r_amt   <= w_src_amt;
      end
    end
  end

  assign bus.out_valid = g_stage[AMT_W-1].r_valid;
  assign bus.out       = g_stage[AMT_W-1].r_word;
  assign bus.out_amt   = g_stage[AMT_W-1].r_amt;

endmodule

// File: tb/tb_barrel_rotator_left_pipe.sv
// Scoreboard bench for barrel_rotator_left_pipe: the driver pushes expected
// results on every accepted word, an independent monitor pops on every output
// transfer and checks value, carried amount, timing and stall behaviour.
module tb_barrel_rotator_left_pipe;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  barrel_rotator_left_pipe_if #(.WIDTH(W), .AMT_W(AW)) bus ();

  barrel_rotator_left_pipe #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [W-1:0]  word;
    logic [AW-1:0] amt;
    int unsigned   acc_cyc;
    int unsigned   stalls_at_push;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;
  int unsigned stalls = 0;

  // Edge counter: after edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  // Reference rotate: bit i of the input lands at position (i+a) mod W
  function automatic logic [W-1:0] rotl_ref(input logic [W-1:0] d, input logic [AW-1:0] a);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(W); i++) r[(i + int'(a)) % int'(W)] = d[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Drive one cycle's inputs (caller is at the negedge) and log an accepted word
  task automatic drive(input logic v, input logic [W-1:0] d, input logic [AW-1:0] a,
                       input logic ordy, input logic [W-1:0] exp_w, output logic acc);
    exp_t e;
    bus.in_valid  = v;
    bus.data      = d;
    bus.amt       = a;
    bus.out_ready = ordy;
    #1;
    acc = v && bus.in_ready && rst_n;
    if (acc) begin
      e.word           = exp_w;
      e.amt            = a;
      e.acc_cyc        = cyc + 1;
      e.stalls_at_push = stalls;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, '0, '0, 1'b1, '0, acc);
    end
  endtask

  // Directed word, retried until accepted (bounded)
  task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a, input logic [W-1:0] exp_w);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      drive(1'b1, d, a, 1'b1, exp_w, acc);
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  // Monitor: pops on output transfers, checks stall stability and in_ready
  logic          have_hold = 1'b0;
  logic [W-1:0]  held_out;
  logic [AW-1:0] held_amt;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        have_hold = 1'b0;
      end else begin
        if (bus.out_valid && have_hold) begin
          check("stall_out_stable", 64'(bus.out), 64'(held_out));
          check("stall_amt_stable", 64'(bus.out_amt), 64'(held_amt));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: got out=0x%0h with empty scoreboard expected no output", bus.out);
          end else begin
            e = q.pop_front();
            check("out_word", 64'(bus.out), 64'(e.word));
            check("out_amt", 64'(bus.out_amt), 64'(e.amt));
            check("latency", 64'(cyc), 64'(e.acc_cyc + 4 + (stalls - e.stalls_at_push)));
          end
        end
        if (bus.out_valid && !bus.out_ready) begin
          check("in_ready_stall", 64'(bus.in_ready), 64'(0));
          held_out  = bus.out;
          held_amt  = bus.out_amt;
          have_hold = 1'b1;
          stalls++;
        end else begin
          have_hold = 1'b0;
        end
      end
    end
  end

  initial begin
    logic          acc;
    logic [W-1:0]  d;
    logic [AW-1:0] a;
    int            sent;
    int            hold_left;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data      = '0;
    bus.amt       = '0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out", 64'(bus.out), 64'(0));
    check("rst_out_amt", 64'(bus.out_amt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Identity and latency
    send(32'h0000_0003, 5'd0, 32'h0000_0003);
    idle(8);

    // Back-to-back
    send(32'h3, 5'd1,  32'h0000_0006);
    send(32'h3, 5'd2,  32'h0000_000C);
    send(32'h3, 5'd30, 32'hC000_0000);
    send(32'h3, 5'd31, 32'h8000_0001);
    // Undo of a rotate-right
    send(32'h8000_0001, 5'd1,  32'h0000_0003);
    send(32'hC000_0000, 5'd2,  32'h0000_0003);
    send(32'h0000_0180, 5'd25, 32'h0000_0003);
    idle(8);

    // Backpressure: 8 words, 4-cycle stall once a result shows up
    sent = 0;
    hold_left = 4;
    for (int t = 0; t < 100 && sent < 8; t++) begin
      @(negedge clk);
      d = $urandom;
      a = AW'(sent * 3 + 1);
      if (bus.out_valid && hold_left > 0) begin
        hold_left--;
        drive(1'b1, d, a, 1'b0, rotl_ref(d, a), acc);
      end else begin
        drive(1'b1, d, a, 1'b1, rotl_ref(d, a), acc);
      end
      if (acc) sent++;
    end
    check("bp_words_sent", 64'(sent), 64'(8));
    idle(10);

    // Bubbles: valid pattern 1,0,1,0
    @(negedge clk); drive(1'b1, 32'h3, 5'd3, 1'b1, 32'h0000_0018, acc);
    @(negedge clk); drive(1'b0, 32'hFFFF_FFFF, 5'd9, 1'b1, '0, acc);
    @(negedge clk); drive(1'b1, 32'h3, 5'd7, 1'b1, 32'h0000_0180, acc);
    @(negedge clk); drive(1'b0, 32'hFFFF_FFFF, 5'd9, 1'b1, '0, acc);
    idle(8);

    // Reset with three words in flight
    send(32'h1234_5678, 5'd4, rotl_ref(32'h1234_5678, 5'd4));
    send(32'h0F0F_0F0F, 5'd9, rotl_ref(32'h0F0F_0F0F, 5'd9));
    send(32'hDEAD_BEEF, 5'd17, rotl_ref(32'hDEAD_BEEF, 5'd17));
    @(negedge clk);
    bus.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_out", 64'(bus.out), 64'(0));
    q.delete();
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    send(32'h3, 5'd15, 32'h0001_8000);
    idle(8);

    // Random traffic with random backpressure
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      d = $urandom;
      a = AW'($urandom_range(0, W - 1));
      drive(($urandom_range(0, 9) < 7), d, a, ($urandom_range(0, 3) != 0), rotl_ref(d, a), acc);
    end

    // Drain with a bounded wait
    for (int t = 0; t < 50 && q.size() != 0; t++) idle(1);
    idle(2);
    check("drain_scoreboard_empty", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
